hsi_vector_engine: RTL and testbench

HSI_VECTOR_ENGINE -- requirements
Module: hsi_vector_engine

---
 rtl/hsi_vector_pkg.sv | 29 ++
 rtl/fifo_cache.sv | 78 +++++++
 rtl/hsi_vector_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_hsi_vector_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_vector_pkg.sv
// Shared definitions for the hyperspectral vector engine: op/error codes,
// FSM state encoding and the accumulator width rule.
package hsi_vector_pkg;

  localparam logic [3:0] OP_CROSS = 4'd1;
  localparam logic [3:0] OP_DOT   = 4'd2;
  localparam logic [3:0] OP_NORM2 = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;

  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_BAD_OP     = 4'd1;
  localparam logic [3:0] ERR_BAD_BANDS  = 4'd2;
  localparam logic [3:0] ERR_ZERO_COUNT = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERROR   = 3'd1,
    S_FETCH   = 3'd2,
    S_LOAD    = 3'd3,
    S_COMPUTE = 3'd4,
    S_WRITE   = 3'd5
  } state_t;

  // Full-precision width of a sum of num_bands_max products.
  function automatic int acc_w(input int comp_w, input int num_bands_max);
    return 2 * comp_w + $clog2(num_bands_max);
  endfunction

endpackage

// File: rtl/fifo_cache.sv
// Synchronous FIFO. SHOW_AHEAD=1 presents the head word combinationally;
// otherwise dout is registered on each pop.
module fifo_cache #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter bit SHOW_AHEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, push_s, pop_s;

  // Push is dropped when full, pop ignored when empty.
  always_comb begin
    push_s  = wr_en && !full_q;
    pop_s   = rd_en && !empty_q;
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign dout = mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [WIDTH-1:0] rd_data_q;
      // Popped word is held until the next pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data_q <= '0;
        else if (pop_s) rd_data_q <= mem_q[rd_ptr_q];
      end
      assign dout = rd_data_q;
    end
  endgenerate

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/hsi_vector_engine.sv
// Pixel-vector engine: pulls vector pairs from two input FIFOs, applies
// CROSS/DOT/NORM2/ADD and pushes one result word per pixel to the output FIFO.
module hsi_vector_engine
  import hsi_vector_pkg::*;
#(
  parameter int COMPONENT_WIDTH = 16,
  parameter int NUM_BANDS_MAX   = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in1_wr_en,
  input  logic [COMPONENT_WIDTH*NUM_BANDS_MAX-1:0] in1_data_in,
  output logic                                     in1_full,
  input  logic                                     in2_wr_en,
  input  logic [COMPONENT_WIDTH*NUM_BANDS_MAX-1:0] in2_data_in,
  output logic                                     in2_full,
  input  logic                                     out_rd_en,
  output logic [COMPONENT_WIDTH*NUM_BANDS_MAX-1:0] out_data_out,
  output logic                                     out_empty,
  input  logic [3:0]                               op_code,
  input  logic [7:0]                               num_bands,
  input  logic [15:0]                              pixel_count,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     pixel_done,
  output logic                                     frame_done,
  output logic [3:0]                               error_code
);

  localparam int CW    = COMPONENT_WIDTH;
  localparam int VW    = COMPONENT_WIDTH * NUM_BANDS_MAX;
  localparam int ACC_W = acc_w(COMPONENT_WIDTH, NUM_BANDS_MAX);

  state_t                   state_q, state_d;
  logic [3:0]               op_q, op_d, err_q, err_d;
  logic [7:0]               nb_q, nb_d, band_q, band_d;
  logic [15:0]              remaining_q, remaining_d;
  logic [VW-1:0]            vec1_q, vec1_d, vec2_q, vec2_d, result_q, result_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, mac_s;
  logic signed [2*CW-1:0]   prod_s;
  logic signed [CW:0]       add_s;
  logic                     busy_q, busy_d, pixel_done_q, pixel_done_d;
  logic                     frame_done_q, frame_done_d;
  logic                     in_rd_s, out_wr_s, op_known_s;
  logic [VW-1:0]            in1_dout, in2_dout;
  logic                     in1_empty, in2_empty, out_full;

  function automatic logic signed [CW-1:0] band(input logic [VW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  function automatic logic signed [2*CW:0] smul(input logic signed [CW-1:0] x,
                                                input logic signed [CW-1:0] y);
    logic signed [2*CW-1:0] p;
    p = x * y;
    return {p[2*CW-1], p};
  endfunction

  // Clamp to the signed component range when the upper bits are not pure sign.
  function automatic logic [CW-1:0] sat(input logic signed [2*CW:0] v);
    if ((&v[2*CW:CW-1]) || !(|v[2*CW:CW-1])) return v[CW-1:0];
    else if (v[2*CW])                        return {1'b1, {(CW-1){1'b0}}};
    else                                     return {1'b0, {(CW-1){1'b1}}};
  endfunction

  fifo_cache #(.WIDTH(VW), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b0)) u_in1_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in1_wr_en), .din(in1_data_in), .full(in1_full),
    .rd_en(in_rd_s), .dout(in1_dout), .empty(in1_empty));

  fifo_cache #(.WIDTH(VW), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b0)) u_in2_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in2_wr_en), .din(in2_data_in), .full(in2_full),
    .rd_en(in_rd_s), .dout(in2_dout), .empty(in2_empty));

  fifo_cache #(.WIDTH(VW), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b1)) u_out_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(out_wr_s), .din(result_q), .full(out_full),
    .rd_en(out_rd_en), .dout(out_data_out), .empty(out_empty));

  // Next-state, datapath and control decode for the job sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    nb_d         = nb_q;
    err_d        = err_q;
    band_d       = band_q;
    remaining_d  = remaining_q;
    vec1_d       = vec1_q;
    vec2_d       = vec2_q;
    result_d     = result_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    pixel_done_d = 1'b0;
    frame_done_d = 1'b0;
    in_rd_s      = 1'b0;
    out_wr_s     = 1'b0;
    add_s        = '0;
    op_known_s   = (op_code == OP_CROSS) || (op_code == OP_DOT) ||
                   (op_code == OP_NORM2) || (op_code == OP_ADD);
    prod_s       = band(vec1_q, int'(band_q)) * band(vec2_q, int'(band_q));
    mac_s        = acc_q + ACC_W'(prod_s);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_bands == 8'd0 || num_bands > 8'(NUM_BANDS_MAX)) begin
            err_d   = ERR_BAD_BANDS;
            state_d = S_ERROR;
          end else if (!op_known_s || (op_code == OP_CROSS && num_bands != 8'd3)) begin
            err_d   = ERR_BAD_OP;
            state_d = S_ERROR;
          end else if (pixel_count == 16'd0) begin
            err_d   = ERR_ZERO_COUNT;
            state_d = S_ERROR;
          end else begin
            op_d        = op_code;
            nb_d        = num_bands;
            remaining_d = pixel_count;
            err_d       = ERR_NONE;
            busy_d      = 1'b1;
            state_d     = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (!start) state_d = S_IDLE;
        else        state_d = S_ERROR;
      end
      S_FETCH: begin
        if (!in1_empty && !in2_empty && !out_full) begin
          in_rd_s = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LOAD: begin
        for (int g = 0; g < NUM_BANDS_MAX; g++) begin
          if (g < int'(nb_q)) begin
            vec1_d[g*CW +: CW] = in1_dout[g*CW +: CW];
            vec2_d[g*CW +: CW] = in2_dout[g*CW +: CW];
          end else begin
            vec1_d[g*CW +: CW] = '0;
            vec2_d[g*CW +: CW] = '0;
          end
        end
        // NORM2 reuses the DOT MAC with vec1 on both operands.
        if (op_q == OP_NORM2) vec2_d = vec1_d;
        else                  vec2_d = vec2_d;
        acc_d   = '0;
        band_d  = 8'd0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        case (op_q)
          OP_CROSS: begin
            result_d = '0;
            result_d[0*CW +: CW] = sat(smul(band(vec1_q, 1), band(vec2_q, 2)) -
                                       smul(band(vec1_q, 2), band(vec2_q, 1)));
            result_d[1*CW +: CW] = sat(smul(band(vec1_q, 2), band(vec2_q, 0)) -
                                       smul(band(vec1_q, 0), band(vec2_q, 2)));
            result_d[2*CW +: CW] = sat(smul(band(vec1_q, 0), band(vec2_q, 1)) -
                                       smul(band(vec1_q, 1), band(vec2_q, 0)));
            state_d = S_WRITE;
          end
          OP_ADD: begin
            for (int g = 0; g < NUM_BANDS_MAX; g++) begin
              add_s = {vec1_q[g*CW+CW-1], vec1_q[g*CW +: CW]} +
                      {vec2_q[g*CW+CW-1], vec2_q[g*CW +: CW]};
              if (g < int'(nb_q)) result_d[g*CW +: CW] = sat({{CW{add_s[CW]}}, add_s});
              else                result_d[g*CW +: CW] = '0;
            end
            state_d = S_WRITE;
          end
          OP_DOT, OP_NORM2: begin
            acc_d  = mac_s;
            band_d = band_q + 8'd1;
            if (band_q == nb_q - 8'd1) begin
              result_d = '0;
              result_d[ACC_W-1:0] = mac_s;
              state_d = S_WRITE;
            end else begin
              state_d = S_COMPUTE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WRITE: begin
        out_wr_s     = 1'b1;
        pixel_done_d = 1'b1;
        remaining_d  = remaining_q - 16'd1;
        if (remaining_q == 16'd1) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single register stage for FSM state, datapath and all control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      nb_q         <= 8'd0;
      err_q        <= ERR_NONE;
      band_q       <= 8'd0;
      remaining_q  <= 16'd0;
      vec1_q       <= '0;
      vec2_q       <= '0;
      result_q     <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      pixel_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      nb_q         <= nb_d;
      err_q        <= err_d;
      band_q       <= band_d;
      remaining_q  <= remaining_d;
      vec1_q       <= vec1_d;
      vec2_q       <= vec2_d;
      result_q     <= result_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      pixel_done_q <= pixel_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign pixel_done = pixel_done_q;
  assign frame_done = frame_done_q;
  assign error_code = err_q;

endmodule

// File: tb/tb_hsi_vector_engine.sv
// Directed self-checking bench for hsi_vector_engine (default parameters).
module tb_hsi_vector_engine;
  import hsi_vector_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in1_wr_en = 1'b0, in2_wr_en = 1'b0, out_rd_en = 1'b0, start = 1'b0;
  logic [127:0] in1_data_in = '0, in2_data_in = '0;
  logic [127:0] out_data_out;
  logic         in1_full, in2_full, out_empty, busy, pixel_done, frame_done;
  logic [3:0]   op_code = 4'd0;
  logic [7:0]   num_bands = 8'd0;
  logic [15:0]  pixel_count = 16'd0;
  logic [3:0]   error_code;

  int n_cmp = 0;
  int n_bad = 0;
  int pd_cnt = 0;
  int lat;
  int pd_before;

  hsi_vector_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in1_wr_en(in1_wr_en), .in1_data_in(in1_data_in), .in1_full(in1_full),
    .in2_wr_en(in2_wr_en), .in2_data_in(in2_data_in), .in2_full(in2_full),
    .out_rd_en(out_rd_en), .out_data_out(out_data_out), .out_empty(out_empty),
    .op_code(op_code), .num_bands(num_bands), .pixel_count(pixel_count),
    .start(start), .busy(busy), .pixel_done(pixel_done), .frame_done(frame_done),
    .error_code(error_code));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_done) pd_cnt <= pd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int b0, input int b1, input int b2, input int b3,
                                      input int b4, input int b5, input int b6, input int b7);
    int b [8];
    logic [127:0] v;
    b = '{b0, b1, b2, b3, b4, b5, b6, b7};
    v = '0;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(b[k]);
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [127:0] v1, input logic [127:0] v2);
    in1_data_in = v1; in2_data_in = v2;
    in1_wr_en = 1'b1; in2_wr_en = 1'b1;
    step(1);
    in1_wr_en = 1'b0; in2_wr_en = 1'b0;
  endtask

  // Job controls are scrambled right after the start edge; the engine must ignore them.
  task automatic pulse_start(input logic [3:0] op, input logic [7:0] nb, input logic [15:0] pc);
    op_code = op; num_bands = nb; pixel_count = pc; start = 1'b1;
    step(1);
    start = 1'b0; op_code = 4'd15; num_bands = 8'd0; pixel_count = 16'd0;
  endtask

  task automatic pop_out();
    out_rd_en = 1'b1;
    step(1);
    out_rd_en = 1'b0;
  endtask

  task automatic wait_pd(input string tag, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!pixel_done && cyc < 60);
    chk({tag, "_pd_seen"}, {127'd0, pixel_done}, 128'd1);
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_pixel_done", {127'd0, pixel_done}, 128'd0);
    chk("rst_frame_done", {127'd0, frame_done}, 128'd0);
    chk("rst_error_code", {124'd0, error_code}, 128'd0);
    chk("rst_in1_full", {127'd0, in1_full}, 128'd0);
    chk("rst_in2_full", {127'd0, in2_full}, 128'd0);
    chk("rst_out_empty", {127'd0, out_empty}, 128'd1);
    rst_n = 1'b1;
    step(2);

    // CROSS (1,2,3)x(4,5,6); upper bands carry junk that must be ignored
    pd_before = pd_cnt;
    push_pair(pk(1, 2, 3, 77, 77, 77, 77, 77), pk(4, 5, 6, -9, -9, -9, -9, -9));
    pulse_start(OP_CROSS, 8'd3, 16'd1);
    chk("cross_busy", {127'd0, busy}, 128'd1);
    wait_pd("cross", lat);
    chk("cross_latency", 128'(lat), 128'd4);
    chk("cross_frame_done", {127'd0, frame_done}, 128'd1);
    chk("cross_busy_end", {127'd0, busy}, 128'd0);
    chk("cross_out_empty", {127'd0, out_empty}, 128'd0);
    chk("cross_data", out_data_out, pk(-3, 6, -3, 0, 0, 0, 0, 0));
    pop_out();
    step(3);
    chk("cross_out_drained", {127'd0, out_empty}, 128'd1);
    chk("cross_one_pixel_done", 128'(pd_cnt - pd_before), 128'd1);

    // DOT of eight 2s with eight 3s = 48, 8 COMPUTE cycles
    push_pair(pk(2, 2, 2, 2, 2, 2, 2, 2), pk(3, 3, 3, 3, 3, 3, 3, 3));
    pulse_start(OP_DOT, 8'd8, 16'd1);
    wait_pd("dot", lat);
    chk("dot_latency", 128'(lat), 128'd11);
    chk("dot_data", out_data_out, 128'd48);
    chk("dot_frame_done", {127'd0, frame_done}, 128'd1);
    pop_out();

    // NORM2 of eight 32767 = 8589410312; vec2 is unused
    push_pair(pk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767),
              pk(-7, -7, -7, -7, -7, -7, -7, -7));
    pulse_start(OP_NORM2, 8'd8, 16'd1);
    wait_pd("norm2", lat);
    chk("norm2_data", out_data_out, 128'd8589410312);
    pop_out();

    // ADD with positive/negative saturation, bands >= 3 forced to zero
    push_pair(pk(32767, -32768, 5, 9, 9, 9, 9, 9), pk(1, -1, 7, 9, 9, 9, 9, 9));
    pulse_start(OP_ADD, 8'd3, 16'd1);
    wait_pd("add", lat);
    chk("add_data", out_data_out, pk(32767, -32768, 12, 0, 0, 0, 0, 0));
    pop_out();

    // Rejected starts must not pop the pre-loaded pair
    push_pair(pk(1, 2, 3, 0, 0, 0, 0, 0), pk(4, 5, 6, 0, 0, 0, 0, 0));
    pulse_start(OP_CROSS, 8'd4, 16'd1);
    chk("err_cross4_code", {124'd0, error_code}, 128'd1);
    chk("err_cross4_busy", {127'd0, busy}, 128'd0);
    step(1);
    pulse_start(OP_DOT, 8'd0, 16'd1);
    chk("err_bands0_code", {124'd0, error_code}, 128'd2);
    step(1);
    pulse_start(4'd7, 8'd3, 16'd1);
    chk("err_badop_code", {124'd0, error_code}, 128'd1);
    step(1);
    pulse_start(OP_ADD, 8'd3, 16'd0);
    chk("err_zero_count_code", {124'd0, error_code}, 128'd3);
    step(4);
    chk("err_held", {124'd0, error_code}, 128'd3);
    chk("err_no_write", {127'd0, out_empty}, 128'd1);
    pulse_start(OP_CROSS, 8'd3, 16'd1);
    chk("err_cleared", {124'd0, error_code}, 128'd0);
    wait_pd("err_recover", lat);
    chk("err_recover_data", out_data_out, pk(-3, 6, -3, 0, 0, 0, 0, 0));
    pop_out();

    // Two-pixel job with only one pair available: stalls in FETCH
    push_pair(pk(100, 200, -300, 0, 0, 0, 0, 0), pk(1, 2, 3, 0, 0, 0, 0, 0));
    pulse_start(OP_ADD, 8'd3, 16'd2);
    wait_pd("pc2_first", lat);
    chk("pc2_first_data", out_data_out, pk(101, 202, -297, 0, 0, 0, 0, 0));
    chk("pc2_first_no_frame", {127'd0, frame_done}, 128'd0);
    pop_out();
    pd_before = pd_cnt;
    step(10);
    chk("pc2_stall_busy", {127'd0, busy}, 128'd1);
    chk("pc2_stall_no_pd", 128'(pd_cnt - pd_before), 128'd0);
    chk("pc2_stall_out_empty", {127'd0, out_empty}, 128'd1);
    push_pair(pk(-5, 10, 32000, 0, 0, 0, 0, 0), pk(-6, -20, 1000, 0, 0, 0, 0, 0));
    wait_pd("pc2_second", lat);
    chk("pc2_second_data", out_data_out, pk(-11, -10, 32767, 0, 0, 0, 0, 0));
    chk("pc2_frame_done", {127'd0, frame_done}, 128'd1);
    pop_out();

    // Reset during DOT COMPUTE, with a spare pair left in the input FIFOs
    push_pair(pk(1, 1, 1, 1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1, 1, 1, 1));
    push_pair(pk(4, 4, 4, 4, 4, 4, 4, 4), pk(4, 4, 4, 4, 4, 4, 4, 4));
    pulse_start(OP_DOT, 8'd8, 16'd1);
    step(3);
    pd_before = pd_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {127'd0, busy}, 128'd0);
    chk("rst_mid_out_empty", {127'd0, out_empty}, 128'd1);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rst_mid_no_write", 128'(pd_cnt - pd_before), 128'd0);
    chk("rst_mid_still_empty", {127'd0, out_empty}, 128'd1);
    pulse_start(OP_DOT, 8'd8, 16'd1);
    step(20);
    chk("rst_flush_stall_busy", {127'd0, busy}, 128'd1);
    chk("rst_flush_no_pd", 128'(pd_cnt - pd_before), 128'd0);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Input FIFO 1 fills after exactly FIFO_DEPTH pushes
    in1_data_in = pk(1, 1, 1, 1, 1, 1, 1, 1);
    in1_wr_en = 1'b1;
    step(15);
    chk("fill_15_not_full", {127'd0, in1_full}, 128'd0);
    step(1);
    chk("fill_16_full", {127'd0, in1_full}, 128'd1);
    step(1);
    in1_wr_en = 1'b0;
    chk("fill_still_full", {127'd0, in1_full}, 128'd1);
    chk("fill_in2_not_full", {127'd0, in2_full}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
